// File: rtl/gray_conv_pipe_if.sv
// -----------------------------------------------------------------------------
// gray_conv_pipe_if
//
// Purpose:
//   Bundles the two valid/ready streams of gray_conv_pipe: the input stream
//   (word plus conversion mode) and the output stream (converted word plus
//   error flag).
//
// Signals:
//   in_valid   producer -> pipe   input word present
//   in_ready   pipe -> producer   pipe accepts input this cycle
//   in_data    producer -> pipe   WIDTH-bit word to convert
//   in_mode    producer -> pipe   00 bin->Gray, 01 Gray->bin, 10 BCD->Gray,
//                                 11 reserved
//   out_valid  pipe -> consumer   result present
//   out_ready  consumer -> pipe   consumer accepts result
//   out_data   pipe -> consumer   converted word
//   out_err    pipe -> consumer   result flagged invalid
//
// Modports:
//   master  the producer/consumer side that surrounds the pipe
//   slave   the pipe itself
// -----------------------------------------------------------------------------
interface gray_conv_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err
  );

endinterface

// File: rtl/gray_conv_pipe.sv
// -----------------------------------------------------------------------------
// gray_conv_pipe
//
// Purpose:
//   Two-stage pipelined code converter with valid/ready handshakes on both
//   sides. Each word carries its own mode:
//     00  binary -> Gray         err = 0
//     01  Gray   -> binary       err = 0
//     10  packed BCD -> Gray     err = 1 if any nibble > 9 (data still produced)
//     11  reserved, passthrough  err = 1
//   Stage 1 captures the raw word and mode, stage 2 captures the converted
//   word and error flag. With out_ready held high the pipe moves one word per
//   cycle; under backpressure it holds up to two words.
//
// Parameters:
//   WIDTH  data width in bits, a multiple of 4 and at least 4. BCD mode treats
//          the word as WIDTH/4 digits.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, clears both stages and outputs
//   bus         gray_conv_pipe_if.slave, input and output streams
//   conv_count  (GCP_STATS_EN only) saturating count of output transfers
//   err_count   (GCP_STATS_EN only) saturating count of output transfers with
//               out_err = 1
//
// Configuration macro:
//   GCP_STATS_EN  when defined, adds the conv_count/err_count ports and their
//                 counters. Conversion behaviour is identical either way.
// -----------------------------------------------------------------------------
module gray_conv_pipe #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_conv_pipe_if.slave bus
`ifdef GCP_STATS_EN
  ,
  output logic [15:0]     conv_count,
  output logic [15:0]     err_count
`endif
);

  localparam int DIGITS = WIDTH / 4;

  typedef enum logic [1:0] {
    MODE_B2G   = 2'b00,
    MODE_G2B   = 2'b01,
    MODE_BCD2G = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Conversion helpers
  // ---------------------------------------------------------------------------

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of the Gray bit at that position and every
  // bit above it, i.e. the parity of the word shifted down to that position.
  // Written as independent reductions so there is no bit-to-bit chain
  // through a single variable.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // A packed-BCD word is invalid if any of its nibbles holds A..F.
  function automatic logic bcd_invalid(input logic [WIDTH-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (x[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  mode_e            s1_mode_q,  s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;

  logic             s1_ready;
  logic             s2_ready;

  logic [WIDTH-1:0] conv_data;
  logic             conv_err;

  // A stage can take a new word when it is empty or when the stage after it
  // is taking its current word in the same cycle. Chaining the readies this
  // way is what gives one word per cycle with no bubble when out_ready is high.
  assign s2_ready     = !s2_valid_q || bus.out_ready;
  assign s1_ready     = !s1_valid_q || s2_ready;
  assign bus.in_ready = s1_ready;

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_err   = s2_err_q;

  // ---------------------------------------------------------------------------
  // Converter between the stages. It works on whatever stage 1 holds; the
  // result only matters in the cycle stage 2 actually loads it.
  // ---------------------------------------------------------------------------
  always_comb begin
    conv_data = s1_data_q;
    conv_err  = 1'b0;
    case (s1_mode_q)
      MODE_B2G: begin
        conv_data = bin2gray(s1_data_q);
        conv_err  = 1'b0;
      end
      MODE_G2B: begin
        conv_data = gray2bin(s1_data_q);
        conv_err  = 1'b0;
      end
      MODE_BCD2G: begin
        // The Gray code is taken over the raw packed bits, not the decimal
        // value, so a bad digit still yields a well-defined word.
        conv_data = bin2gray(s1_data_q);
        conv_err  = bcd_invalid(s1_data_q);
      end
      default: begin
        conv_data = s1_data_q;
        conv_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state for both stages. A stage that is not ready holds everything.
  // A ready stage takes the valid bit from upstream every cycle, but only
  // overwrites its payload when a word is really arriving, so input data
  // presented without in_valid never reaches the registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;

    if (s1_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.in_data;
        s1_mode_d = mode_e'(bus.in_mode);
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = conv_data;
        s2_err_d  = conv_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers. Reset empties the pipe and zeroes the visible output
  // word so nothing stale can be presented after reset is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_B2G;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

`ifdef GCP_STATS_EN
  // ---------------------------------------------------------------------------
  // Transfer statistics. Both counters stick at all-ones rather than wrapping,
  // so a long run can never read as a small count.
  // ---------------------------------------------------------------------------
  logic        out_fire;
  logic [15:0] conv_count_q, conv_count_d;
  logic [15:0] err_count_q,  err_count_d;

  assign out_fire = s2_valid_q && bus.out_ready;

  always_comb begin
    conv_count_d = conv_count_q;
    err_count_d  = err_count_q;
    if (out_fire) begin
      if (conv_count_q != 16'hFFFF) begin
        conv_count_d = conv_count_q + 16'd1;
      end
      if (s2_err_q && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count_q <= 16'd0;
      err_count_q  <= 16'd0;
    end else begin
      conv_count_q <= conv_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign conv_count = conv_count_q;
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_pipe
//
// Purpose:
//   Self-checking bench for gray_conv_pipe at WIDTH = 8. Directed vectors with
//   hand-worked results, a full 256-value bin->Gray->bin round trip, a
//   backpressure run, reset in mid-flight and, when GCP_STATS_EN is defined,
//   the transfer counters including saturation.
// -----------------------------------------------------------------------------
module tb_gray_conv_pipe;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  gray_conv_pipe_if #(.WIDTH(WIDTH)) bus ();

`ifdef GCP_STATS_EN
  logic [15:0] conv_count;
  logic [15:0] err_count;
`endif

  gray_conv_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef GCP_STATS_EN
    ,
    .conv_count (conv_count),
    .err_count  (err_count)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         assertCount = 0;
  int         failCount   = 0;

  logic [7:0] txData[$];
  logic [1:0] txMode[$];
  logic [7:0] rxData[$];
  logic       rxErr[$];
  int         holdCycles;
  int         lastCycles;
  int         sentAtHoldEnd;
  logic       readyAtCycle2;
  logic [7:0] grays[256];

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference conversion for the looped tests, returns {err, data}.
  function automatic logic [8:0] modelConv(input logic [7:0] x, input logic [1:0] m);
    logic [7:0] r;
    logic       e;
    logic       acc;
    r   = '0;
    e   = 1'b0;
    acc = 1'b0;
    case (m)
      2'b00: r = x ^ {1'b0, x[7:1]};
      2'b01: begin
        for (int i = 7; i >= 0; i--) begin
          acc  = acc ^ x[i];
          r[i] = acc;
        end
      end
      2'b10: begin
        r = x ^ {1'b0, x[7:1]};
        e = (x[7:4] > 4'd9) || (x[3:0] > 4'd9);
      end
      default: begin
        r = x;
        e = 1'b1;
      end
    endcase
    return {e, r};
  endfunction

  // One word through an empty pipe with out_ready high; checks the result
  // appears exactly two cycles after the word is presented and then drains.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode,
                               input logic [7:0] expData, input logic expErr,
                               input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_mode   = mode;
    #1;
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
    bus.in_mode  = 2'b11;
    #1;
    checkOutput({tag, " early out_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'(expData));
    checkOutput({tag, " out_err"}, 32'(bus.out_err), 32'(expErr));
    @(negedge clk);
    #1;
    checkOutput({tag, " drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Streams txData/txMode into the pipe while collecting results, with
  // out_ready held low for the first holdCycles cycles. Decisions are made
  // after the negedge drive settles; the matching transfers happen on the
  // following posedge.
  task automatic runStream(input int maxCycles, input string tag);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    rxData.delete();
    rxErr.delete();
    sentAtHoldEnd = -1;
    readyAtCycle2 = 1'b1;
    while ((cyc < maxCycles) && (rxData.size() < txData.size())) begin
      @(negedge clk);
      bus.out_ready = (cyc >= holdCycles);
      if (sent < txData.size()) begin
        bus.in_valid = 1'b1;
        bus.in_data  = txData[sent];
        bus.in_mode  = txMode[sent];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hC3;
        bus.in_mode  = 2'b11;
      end
      #1;
      if (cyc == 2) readyAtCycle2 = bus.in_ready;
      if (bus.in_valid && bus.in_ready) sent++;
      if (cyc == holdCycles - 1) sentAtHoldEnd = sent;
      if (bus.out_valid && bus.out_ready) begin
        rxData.push_back(bus.out_data);
        rxErr.push_back(bus.out_err);
      end
      cyc++;
    end
    lastCycles = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput({tag, " word count"}, 32'(rxData.size()), 32'(txData.size()));
  endtask

  initial begin
    logic [7:0] bpD[8];
    logic [1:0] bpM[8];
    logic [8:0] exp9;
    int         staleSeen;

    bpD = '{8'h12, 8'h34, 8'h59, 8'h5A, 8'hA5, 8'h00, 8'hFF, 8'h87};
    bpM = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    holdCycles    = 0;

    // Reset state.
    #2;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset out_err", 32'(bus.out_err), 32'd0);
`ifdef GCP_STATS_EN
    checkOutput("reset conv_count", 32'(conv_count), 32'd0);
    checkOutput("reset err_count", 32'(err_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    // Directed single-word vectors.
    $display("[TB] directed vectors");
    applyStimulus(8'h2D, 2'b00, 8'h3B, 1'b0, "b2g 2D");
    applyStimulus(8'h3B, 2'b01, 8'h2D, 1'b0, "g2b 3B");
    applyStimulus(8'h59, 2'b10, 8'h75, 1'b0, "bcd 59");
    applyStimulus(8'h5A, 2'b10, 8'h77, 1'b1, "bcd 5A");
    applyStimulus(8'hA5, 2'b11, 8'hA5, 1'b1, "rsvd A5");
    applyStimulus(8'h99, 2'b10, 8'hD5, 1'b0, "bcd 99");
    applyStimulus(8'hA0, 2'b10, 8'hF0, 1'b1, "bcd A0");
    applyStimulus(8'h80, 2'b01, 8'hFF, 1'b0, "g2b 80");
    applyStimulus(8'hFF, 2'b00, 8'h80, 1'b0, "b2g FF");

    // Full sweep bin->Gray at full throughput, then Gray->bin back.
    $display("[TB] 256-value round trip");
    txData.delete();
    txMode.delete();
    for (int i = 0; i < 256; i++) begin
      txData.push_back(8'(i));
      txMode.push_back(2'b00);
    end
    holdCycles = 0;
    runStream(400, "sweep b2g");
    checkOutput("sweep throughput cycles", 32'(lastCycles), 32'd258);
    for (int i = 0; i < 256; i++) begin
      exp9 = modelConv(8'(i), 2'b00);
      grays[i] = (i < rxData.size()) ? rxData[i] : 8'h00;
      checkOutput($sformatf("sweep gray %0d", i), 32'(grays[i]), 32'(exp9[7:0]));
    end
    txData.delete();
    txMode.delete();
    for (int i = 0; i < 256; i++) begin
      txData.push_back(grays[i]);
      txMode.push_back(2'b01);
    end
    runStream(400, "sweep g2b");
    for (int i = 0; i < 256; i++) begin
      checkOutput($sformatf("round trip %0d", i),
                  32'((i < rxData.size()) ? rxData[i] : 8'h00), 32'(i));
    end

    // Backpressure: consumer stalls for 5 cycles while 8 words are offered.
    $display("[TB] backpressure");
    txData.delete();
    txMode.delete();
    for (int i = 0; i < 8; i++) begin
      txData.push_back(bpD[i]);
      txMode.push_back(bpM[i]);
    end
    holdCycles = 5;
    runStream(100, "bp");
    holdCycles = 0;
    checkOutput("bp accepted while stalled", 32'(sentAtHoldEnd), 32'd2);
    checkOutput("bp in_ready when full", 32'(readyAtCycle2), 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp9 = modelConv(bpD[i], bpM[i]);
      checkOutput($sformatf("bp data %0d", i),
                  32'((i < rxData.size()) ? rxData[i] : 8'h00), 32'(exp9[7:0]));
      checkOutput($sformatf("bp err %0d", i),
                  32'((i < rxErr.size()) ? rxErr[i] : 1'b0), 32'(exp9[8]));
    end

    // Reset with two words in flight.
    $display("[TB] reset mid-flight");
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.in_mode   = 2'b00;
    @(negedge clk);
    bus.in_data   = 8'h22;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    checkOutput("inflight out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("inflight out_data", 32'(bus.out_data), 32'h19);
    checkOutput("inflight in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset out_data", 32'(bus.out_data), 32'd0);
    checkOutput("midreset out_err", 32'(bus.out_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    staleSeen     = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) staleSeen++;
    end
    checkOutput("no stale word", 32'(staleSeen), 32'd0);
    applyStimulus(8'h0F, 2'b00, 8'h08, 1'b0, "after reset 0F");

`ifdef GCP_STATS_EN
    // Counters: 3 valid-mode words plus 2 reserved-mode words from a clean reset.
    $display("[TB] statistics");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txData.delete();
    txMode.delete();
    txData = '{8'h2D, 8'h3B, 8'h59, 8'hA5, 8'h33};
    txMode = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    runStream(50, "stats");
    checkOutput("stats conv_count", 32'(conv_count), 32'd5);
    checkOutput("stats err_count", 32'(err_count), 32'd2);

    // Well over 65535 further transfers: conv_count must stick at all-ones.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    bus.in_mode   = 2'b00;
    repeat (65545) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("saturated conv_count", 32'(conv_count), 32'hFFFF);
    checkOutput("saturated err_count", 32'(err_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
